// File: rtl/wrr_pkg.sv
// Shared constants and helpers for the weighted round-robin arbiter family.
package wrr_pkg;

  localparam int WRR_NUM_VC_DEF = 4;
  localparam int WRR_DATA_W_DEF = 4;
  localparam int WRR_WGT_W_DEF  = 3;

  localparam int VCHANEL0 = 0;
  localparam int VCHANEL1 = 1;
  localparam int VCHANEL2 = 2;
  localparam int VCHANEL3 = 3;

  // Index width for n channels; never narrower than one bit.
  function automatic int wrr_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_next_eligible.sv
// Rotating-priority finder: first set bit of eligible_i scanning start_i,
// start_i+1, ... modulo N.
module wrr_next_eligible
  import wrr_pkg::*;
#(
  parameter int N     = WRR_NUM_VC_DEF,
  parameter int IDX_W = wrr_idx_w(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand_idx [N];
  logic [N-1:0]     cand_hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    // One extra bit holds start+offset before the modulo-N fold.
    assign sum = {1'b0, start_i} + (IDX_W + 1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W + 1)'(N)) ?
                          IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];
    assign cand_hit[gi] = eligible_i[cand_idx[gi]];
  end

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found_o = 1'b1;
        idx_o   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter_param.sv
// Weighted round-robin mux: pops one non-empty virtual channel per cycle,
// honouring per-channel burst credits and downstream back-pressure.
module wrr_arbiter_param
  import wrr_pkg::*;
#(
  parameter  int NUM_VC = WRR_NUM_VC_DEF,
  parameter  int DATA_W = WRR_DATA_W_DEF,
  parameter  int WGT_W  = WRR_WGT_W_DEF,
  localparam int IDX_W  = wrr_idx_w(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC*WGT_W-1:0]  vc_weight,
  input  logic                     dst_full,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [IDX_W-1:0]         grant_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VC - 1);

  logic [DATA_W-1:0] data_arr [NUM_VC];
  logic [WGT_W-1:0]  wgt_arr  [NUM_VC];
  logic [NUM_VC-1:0] eligible;

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_unpack
    assign data_arr[gi] = vc_data[gi*DATA_W +: DATA_W];
    assign wgt_arr[gi]  = vc_weight[gi*WGT_W +: WGT_W];
    assign eligible[gi] = !vc_empty[gi] && (wgt_arr[gi] != '0);
  end

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [WGT_W-1:0]  credit_q, credit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  grant_q, grant_d;

  logic [IDX_W-1:0] scan_start;
  logic             scan_found;
  logic [IDX_W-1:0] scan_idx;
  logic             owner_keep;
  logic [IDX_W-1:0] sel;
  logic             go;

  // Scan begins just after the owner so the owner itself is tried last.
  assign scan_start = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;

  wrr_next_eligible #(
    .N     (NUM_VC),
    .IDX_W (IDX_W)
  ) u_next (
    .eligible_i (eligible),
    .start_i    (scan_start),
    .found_o    (scan_found),
    .idx_o      (scan_idx)
  );

  assign owner_keep = eligible[ptr_q] && (credit_q != '0);
  assign sel        = owner_keep ? ptr_q : scan_idx;
  assign go         = enb && !rst && !dst_full && scan_found;

  always_comb begin
    vc_pop = '0;
    if (go) begin
      vc_pop[sel] = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    data_d   = data_q;
    grant_d  = grant_q;
    valid_d  = go;
    if (go) begin
      data_d  = data_arr[sel];
      grant_d = sel;
      if (owner_keep) begin
        credit_d = credit_q - WGT_W'(1);
      end else begin
        // New burst: weight is sampled only here; leftover credit is dropped.
        ptr_d    = sel;
        credit_d = wgt_arr[sel] - WGT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= LAST_IDX;
      credit_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_idx = grant_q;

endmodule
